// File: rtl/icache_resp.sv
// rtl/icache_resp.sv - direct-mapped instruction cache responder with line-fill handshake
//
// Ports:
//   clk, nRst          clock (rising edge), asynchronous active-low reset
//   pc, fetchEn        fetch word address and request valid
//   flush              invalidate all lines (single-cycle pulse)
//   instr, instrValid  instruction word for pc and its valid flag
//   stall              holds the fetch stage (fetch hlt)
//   memReq, memAddr    line-fill request and line address (pc[15:2] at miss)
//   memRdy, memData    line-fill completion pulse and 4-word line data
module icache_resp #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 9
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [15:0] pc,
    input  logic        fetchEn,
    input  logic        flush,
    output logic [15:0] instr,
    output logic        instrValid,
    output logic        stall,
    output logic        memReq,
    output logic [13:0] memAddr,
    input  logic        memRdy,
    input  logic [63:0] memData
);

    localparam int LINES = 1 << INDEX_W;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t state, state_nx;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [63:0]      data_arr [LINES];
    logic             drop_fill;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   ptag;
    logic [INDEX_W-1:0] fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic [63:0]        line;
    logic               hit;
    logic               miss;
    logic               fill_done;
    logic               keep_fill;

    assign idx      = pc[INDEX_W+1:2];
    assign ptag     = pc[15:INDEX_W+2];
    assign fill_idx = memAddr[INDEX_W-1:0];
    assign fill_tag = memAddr[13:INDEX_W];
    assign line     = data_arr[idx];

    assign hit       = fetchEn & valid[idx] & (tag_arr[idx] == ptag);
    assign miss      = fetchEn & ~hit & (state == IDLE);
    assign fill_done = (state == FILL) & memRdy;
    // A flush anywhere in the fill, including the completing cycle, discards the line.
    assign keep_fill = fill_done & ~drop_fill & ~flush;

    assign memReq     = (state == FILL);
    assign instrValid = hit & (state == IDLE);
    assign stall      = miss | (state == FILL);

    always_comb begin
        instr = 16'h0000;
        if (instrValid) begin
            case (pc[1:0])
                2'd0:    instr = line[15:0];
                2'd1:    instr = line[31:16];
                2'd2:    instr = line[47:32];
                default: instr = line[63:48];
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (miss)   state_nx = FILL;
            FILL:    if (memRdy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            memAddr   <= '0;
            drop_fill <= 1'b0;
            valid     <= '0;
        end else begin
            state <= state_nx;
            if (miss) begin
                memAddr <= pc[15:2];
            end
            // The request is never aborted; a flush only marks its data for discard.
            if (state == FILL) begin
                if (memRdy) begin
                    drop_fill <= 1'b0;
                end else if (flush) begin
                    drop_fill <= 1'b1;
                end
            end
            if (flush) begin
                valid <= '0;
            end else if (keep_fill) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (keep_fill) begin
            tag_arr[fill_idx]  <= fill_tag;
            data_arr[fill_idx] <= memData;
        end
    end

endmodule

// File: tb/tb_icache_resp.sv
// tb/tb_icache_resp.sv - randomized and directed bench for icache_resp against a line-address reference model
module tb_icache_resp;

    logic        clk;
    logic        nRst;
    logic [15:0] pc;
    logic        fetchEn;
    logic        flush;
    logic [15:0] instr;
    logic        instrValid;
    logic        stall;
    logic        memReq;
    logic [13:0] memAddr;
    logic        memRdy;
    logic [63:0] memData;

    icache_resp #(.INDEX_W(5), .TAG_W(9)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .pc         (pc),
        .fetchEn    (fetchEn),
        .flush      (flush),
        .instr      (instr),
        .instrValid (instrValid),
        .stall      (stall),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memRdy     (memRdy),
        .memData    (memData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main memory contents: the word at any address is that address xor a constant.
    localparam logic [15:0] KEY = 16'hA5A0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: which line address each index currently holds, plus the fill transaction.
    bit          m_valid [32];
    logic [13:0] m_la    [32];
    bit          m_fill;
    bit          m_drop;
    logic [13:0] m_addr;
    int          stall_cnt;

    function automatic logic [63:0] line_of(input logic [13:0] la);
        logic [63:0] l;
        for (int n = 0; n < 4; n++) l[n*16 +: 16] = {la, 2'(n)} ^ KEY;
        return l;
    endfunction

    function automatic bit m_hit();
        return fetchEn && m_valid[pc[6:2]] && (m_la[pc[6:2]] == pc[15:2]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_valid[i] = 0;
        m_fill = 0;
        m_drop = 0;
        m_addr = '0;
    endtask

    // Drive one cycle's inputs (at posedge+1), settle, and compare against the model.
    task automatic setin(input bit fe, input logic [15:0] p, input bit fl, input bit rdy);
        bit h;
        fetchEn = fe;
        pc      = p;
        flush   = fl;
        memRdy  = rdy;
        memData = m_fill ? line_of(m_addr) : {$urandom, $urandom};
        #3;
        h = m_hit();
        chk("stall", 64'(stall), 64'((fe && !h && !m_fill) || m_fill));
        chk("instrValid", 64'(instrValid), 64'(h && !m_fill));
        chk("instr", 64'(instr), (h && !m_fill) ? 64'(p ^ KEY) : 64'h0);
        chk("memReq", 64'(memReq), 64'(m_fill));
        chk("memAddr", 64'(memAddr), 64'(m_addr));
        if (stall) stall_cnt++;
    endtask

    task automatic edge_();
        bit h;
        logic [4:0] a;
        @(posedge clk);
        h = m_hit();
        a = m_addr[4:0];
        if (!m_fill) begin
            if (fetchEn && !h) begin
                m_fill = 1;
                m_addr = pc[15:2];
            end
        end else if (memRdy) begin
            if (!m_drop && !flush) begin
                m_valid[a] = 1;
                m_la[a]    = m_addr;
            end
            m_fill = 0;
            m_drop = 0;
        end else if (flush) begin
            m_drop = 1;
        end
        if (flush) for (int i = 0; i < 32; i++) m_valid[i] = 0;
        #1;
    endtask

    task automatic cycle(input bit fe, input logic [15:0] p, input bit fl, input bit rdy);
        setin(fe, p, fl, rdy);
        edge_();
    endtask

    // Miss on p, hold memReq for wt cycles, then return the line.
    task automatic fill(input logic [15:0] p, input int wt);
        cycle(1, p, 0, 0);
        for (int i = 0; i < wt - 1; i++) cycle(1, p, 0, 0);
        cycle(1, p, 0, 1);
    endtask

    initial begin
        m_reset();
        nRst    = 1'b0;
        fetchEn = 1'b1;
        pc      = 16'h0000;
        flush   = 1'b0;
        memRdy  = 1'b0;
        memData = '0;
        @(posedge clk);
        #1;
        // Reset state: stall follows fetchEn, nothing else active.
        setin(1, 16'h0005, 0, 0);
        chk("rst_stall_fe1", 64'(stall), 64'd1);
        fetchEn = 1'b0;
        #1;
        chk("rst_stall_fe0", 64'(stall), 64'd0);
        chk("rst_memReq", 64'(memReq), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        edge_();
        nRst = 1'b1;

        // Cold miss at pc 5: memRdy after three memReq cycles, five stall cycles.
        stall_cnt = 0;
        cycle(1, 16'h0005, 0, 0);
        setin(1, 16'h0005, 0, 0);
        chk("cold_memAddr", 64'(memAddr), 64'h0001);
        edge_();
        fill_rest: begin
            cycle(1, 16'h0005, 0, 0);
            cycle(1, 16'h0005, 0, 0);
            cycle(1, 16'h0005, 0, 1);
        end
        chk("cold_stall_cycles", 64'(stall_cnt), 64'd5);
        setin(1, 16'h0005, 0, 0);
        chk("cold_instr", 64'(instr), 64'hA5A5);
        chk("cold_valid", 64'(instrValid), 64'd1);
        edge_();

        // Line hits across the filled line.
        for (int i = 4; i < 8; i++) begin
            setin(1, 16'(i), 0, 0);
            chk("sweep_hit", 64'(instrValid), 64'd1);
            chk("sweep_memReq", 64'(memReq), 64'd0);
            edge_();
        end

        // Conflict eviction: 0x84 replaces 0x04 in the same index.
        cycle(1, 16'h0084, 0, 0);
        setin(1, 16'h0084, 0, 0);
        chk("conflict_memAddr", 64'(memAddr), 64'h0021);
        edge_();
        cycle(1, 16'h0084, 0, 1);
        cycle(1, 16'h0084, 0, 0);
        setin(1, 16'h0004, 0, 0);
        chk("conflict_remiss", 64'(stall), 64'd1);
        edge_();

        // Flush one cycle into the fill: request held, data dropped, line refetched.
        cycle(1, 16'h0004, 1, 0);
        setin(1, 16'h0004, 0, 0);
        chk("flush_memReq_held", 64'(memReq), 64'd1);
        edge_();
        cycle(1, 16'h0004, 0, 1);
        setin(1, 16'h0004, 0, 0);
        chk("flush_remiss", 64'(stall), 64'd1);
        edge_();
        setin(1, 16'h0004, 0, 1);
        chk("flush_refill_addr", 64'(memAddr), 64'h0001);
        edge_();
        cycle(1, 16'h0004, 0, 0);

        // Flush in IDLE: same-cycle lookup still hits, next cycle misses.
        setin(1, 16'h0006, 1, 0);
        chk("idle_flush_hit", 64'(instrValid), 64'd1);
        edge_();
        fill(16'h0006, 2);
        // Flush coincident with the completing memRdy leaves the line invalid.
        cycle(1, 16'h0010, 0, 0);
        cycle(1, 16'h0010, 1, 1);
        setin(1, 16'h0010, 0, 0);
        chk("flush_wins", 64'(stall), 64'd1);
        edge_();
        cycle(1, 16'h0010, 0, 1);

        // Asynchronous reset while memReq is high.
        fill(16'h0005, 1);
        cycle(1, 16'h0085, 0, 0);
        #1;
        nRst = 1'b0;
        #1;
        chk("async_memReq", 64'(memReq), 64'd0);
        chk("async_stall", 64'(stall), 64'd1);
        chk("async_memAddr", 64'(memAddr), 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        nRst = 1'b1;
        setin(1, 16'h0005, 0, 0);
        chk("post_rst_miss", 64'(stall), 64'd1);
        edge_();
        cycle(1, 16'h0005, 0, 1);

        // Spurious memRdy in IDLE with fetchEn low.
        setin(0, 16'h0084, 0, 1);
        chk("spur_stall", 64'(stall), 64'd0);
        chk("spur_valid", 64'(instrValid), 64'd0);
        edge_();
        setin(1, 16'h0084, 0, 0);
        chk("spur_no_write", 64'(stall), 64'd1);
        edge_();
        cycle(1, 16'h0084, 0, 1);

        // Randomized traffic over a few indices and tags to force conflicts.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] p;
            bit rdy;
            p   = {7'd0, 2'($urandom_range(0, 3)), 3'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            rdy = m_fill ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cycle($urandom_range(0, 4) != 0, p, $urandom_range(0, 19) == 0, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache_resp.md
Name: icache_resp

Overview:
- Instruction-side responder for the fetch stage.
- Accepts the fetch PC, returns the 16-bit instruction word, and raises `stall` (wired to the fetch stage `hlt`) on a miss.
- Direct-mapped cache of 4-word lines, refilled from main memory through a req/rdy line-fill handshake.
- Sits between the fetch stage and the memory arbiter.

Parameters:
- INDEX_W, 5, line index bits (2^INDEX_W lines; default 32 lines).
- TAG_W, 9, tag bits; must equal 16 - INDEX_W - 2.

Ports:
- clk  input  1  clock, rising edge.
- nRst  input  1  reset, asynchronous, active-low.
- pc  input  16  fetch word address.
  - Offset = pc[1:0].
  - Index = pc[INDEX_W+1:2].
  - Tag = pc[15:INDEX_W+2].
- fetchEn  input  1  fetch request valid this cycle.
- flush  input  1  invalidate all lines (single-cycle pulse).
- instr  output  16  instruction word for pc.
- instrValid  output  1  instr is valid this cycle.
- stall  output  1  hold the fetch stage; drives fetch `hlt`.
- memReq  output  1  line-fill request to memory.
- memAddr  output  14  line address (pc[15:2] captured at miss).
- memRdy  input  1  memory line data valid, one-cycle pulse.
- memData  input  64  fill line; word n is at memData[16n+15:16n].

Behaviour:
- Storage:
  - Per line: valid bit, tag, four 16-bit words.
  - Valid bits are registers, cleared by reset.
  - Tag/data arrays have no reset.
- States: IDLE, FILL.
- Lookup is combinational in IDLE:
  - hit = fetchEn & valid[idx] & (tag[idx] == pc tag).
  - instr = data[idx][offset] on hit, else 16'h0000.
  - instrValid = hit & (state == IDLE).
  - stall = (fetchEn & ~hit & state == IDLE) | (state == FILL).
  - stall is 0 when fetchEn = 0.
- IDLE, on a miss:
  - Capture pc[15:2] into memAddr.
  - Next state FILL; memReq goes 1 from the next cycle (registered).
- FILL:
  - memReq = 1, and memAddr is held stable.
  - instrValid = 0, stall = 1.
  - memRdy is sampled only in FILL; memRdy in IDLE is ignored.
- FILL, on memRdy = 1 at an edge:
  - Write memData into data[memAddr index].
  - Write the tag and set valid.
  - Next state IDLE with memReq = 0.
  - The following cycle re-looks up the current pc; it normally hits.
- Miss latency: 2 + N cycles from the miss cycle to the hit cycle, where N = cycles memReq is high before memRdy.
- Replacement: direct-mapped; a fill overwrites its line unconditionally (conflict eviction).
- flush in IDLE: all valid bits clear at the edge; the lookup in the same cycle still uses the old valid bits.
- flush in FILL:
  - All valid bits clear, and a dropFill flag is set.
  - The transaction is not aborted: memReq stays 1 until memRdy.
  - On memRdy the data is discarded (valid not set), dropFill clears, and the block goes IDLE.
- flush coincident with a FILL-completing memRdy: the flush wins; the line is left invalid.
- pc change during FILL: the fill completes for the captured memAddr, and the return-to-IDLE lookup uses the new pc.
  - The fetch stage holds pc while stalled, but the block does not rely on it.
- Reset, asynchronous at any time including mid-FILL:
  - state = IDLE, memReq = 0, memAddr = 0, dropFill = 0, all valid = 0.
  - Outputs after reset: instr = 0, instrValid = 0, stall = fetchEn.
  - The memory side must tolerate an abandoned request.
- No write path: the instruction space is read-only to this block.

Test Plan:
- Cold miss:
  - Stimulus: reset, fetchEn = 1, pc = 16'h0005; memory asserts memRdy 3 cycles after memReq with word1 = 16'hA5A5.
  - Required: stall = 1 for 5 cycles; memReq high with memAddr = 14'h0001 until memRdy.
  - Required: next cycle instr = 16'hA5A5, instrValid = 1, stall = 0.
- Line hits:
  - Stimulus: after the fill above, sweep pc = 4..7.
  - Required: four consecutive hits returning memData words 0..3, and memReq remains 0.
- Conflict:
  - Stimulus: fill pc = 16'h0004, then fetch pc = 16'h0084 (same index, different tag).
  - Required: miss with memAddr = 14'h0021; after the fill, pc = 16'h0004 misses again.
- Flush mid-fill:
  - Stimulus: pulse flush 1 cycle into FILL.
  - Required: memReq held until memRdy; after IDLE the same pc misses and issues a new fill with the same memAddr.
- Reset mid-fill:
  - Stimulus: drop nRst while memReq = 1.
  - Required: memReq = 0 immediately (asynchronous); previously filled lines miss after release.
- Idle/spurious:
  - Stimulus: fetchEn = 0 with memRdy pulsed in IDLE.
  - Required: stall = 0, instrValid = 0, no state change, no array write.
